// File: rtl/armleo_round_robin_dispatcher_if.sv
// Handshake bundle for the round-robin dispatcher: one valid/ready producer
// stream in, WIDTH registered valid/ready consumer channels out.
interface armleo_round_robin_dispatcher_if #(
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int CH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH-1:0]       in_data;
    logic [CH_W-1:0]             in_channel;
    logic [WIDTH-1:0]            out_valid;
    logic [WIDTH-1:0]            out_ready;
    logic [WIDTH*DATA_WIDTH-1:0] out_data;

    // Producer and consumers together form the master side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, in_channel, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, in_channel, out_valid, out_data
    );
endinterface

// File: rtl/armleo_round_robin_dispatcher.sv
// One-to-N round-robin work distributor: each accepted beat lands in the
// one-entry slot of the first free channel at or after the priority pointer.
module armleo_round_robin_dispatcher #(
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    armleo_round_robin_dispatcher_if.slave  bus
);
    localparam int CH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CH_W-1:0]       pointer;
    logic [CH_W-1:0]       pointer_next;
    logic [CH_W-1:0]       sel;
    logic [CH_W:0]         cand;
    logic                  found;
    logic                  accept;
    logic [WIDTH-1:0]      free;
    logic [WIDTH-1:0]      load;
    logic [WIDTH-1:0]      slot_valid;
    logic [DATA_WIDTH-1:0] slot_data [WIDTH];

    // A slot draining this cycle is as good as empty.
    assign free   = ~slot_valid | bus.out_ready;
    assign accept = bus.in_valid && (|free);

    // Scan from pointer upward with an explicit wrap so non-power-of-two
    // WIDTH never yields an out-of-range channel.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cand = {1'b0, pointer} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(WIDTH))
                cand = cand - (CH_W+1)'(WIDTH);
            if (!found && free[cand[CH_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        pointer_next = '0;
        if (sel != CH_W'(WIDTH-1))
            pointer_next = sel + CH_W'(1);
    end

    always_comb begin
        load = '0;
        if (accept)
            load[sel] = 1'b1;
    end

    // Idle and stalled cycles leave priority where it is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pointer <= '0;
        else if (accept)
            pointer <= pointer_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            for (int j = 0; j < WIDTH; j++)
                slot_data[j] <= '0;
        end else begin
            for (int j = 0; j < WIDTH; j++) begin
                if (load[j]) begin
                    slot_valid[j] <= 1'b1;
                    slot_data[j]  <= bus.in_data;
                end else if (bus.out_ready[j]) begin
                    slot_valid[j] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready   = |free;
    assign bus.in_channel = sel;
    assign bus.out_valid  = slot_valid;

    for (genvar g = 0; g < WIDTH; g++) begin : g_out
        assign bus.out_data[g*DATA_WIDTH +: DATA_WIDTH] = slot_data[g];
    end
endmodule

// File: tb/tb_armleo_round_robin_dispatcher.sv
// Directed, table-driven bench for the round-robin dispatcher (WIDTH=4),
// plus a WIDTH=3 instance for the non-power-of-two wrap.
module tb_armleo_round_robin_dispatcher;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    armleo_round_robin_dispatcher_if #(.WIDTH(4), .DATA_WIDTH(32)) ifc4 ();
    armleo_round_robin_dispatcher_if #(.WIDTH(3), .DATA_WIDTH(32)) ifc3 ();

    armleo_round_robin_dispatcher #(.WIDTH(4), .DATA_WIDTH(32)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc4.slave)
    );

    armleo_round_robin_dispatcher #(.WIDTH(3), .DATA_WIDTH(32)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic [3:0]  ready;
        logic        exp_ready;
        logic        chk_chan;
        logic [1:0]  exp_chan;
        logic [3:0]  exp_ovalid;
        int          chk_slot;
        logic [31:0] exp_odata;
    } vec_t;

    vec_t vec_q[$];

    function automatic void add(input logic v, input logic [31:0] d, input logic [3:0] r,
                                input logic er, input logic cc, input logic [1:0] ec,
                                input logic [3:0] eov, input int cs, input logic [31:0] eod);
        vec_t t;
        t.valid = v; t.data = d; t.ready = r;
        t.exp_ready = er; t.chk_chan = cc; t.exp_chan = ec;
        t.exp_ovalid = eov; t.chk_slot = cs; t.exp_odata = eod;
        vec_q.push_back(t);
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive at the falling edge, check combinational outputs just after,
    // then check the registered slots just after the following rising edge.
    task automatic apply_stimulus(input vec_t v, input int idx);
        @(negedge clk);
        ifc4.in_valid  = v.valid;
        ifc4.in_data   = v.data;
        ifc4.out_ready = v.ready;
        #1;
        check_output($sformatf("v%0d in_ready", idx), 64'(ifc4.in_ready), 64'(v.exp_ready));
        if (v.chk_chan)
            check_output($sformatf("v%0d in_channel", idx), 64'(ifc4.in_channel), 64'(v.exp_chan));
        @(posedge clk);
        #1;
        check_output($sformatf("v%0d out_valid", idx), 64'(ifc4.out_valid), 64'(v.exp_ovalid));
        check_output($sformatf("v%0d out_data[%0d]", idx, v.chk_slot),
                     64'(ifc4.out_data[v.chk_slot*32 +: 32]), 64'(v.exp_odata));
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i < hi; i++)
            apply_stimulus(vec_q[i], i);
        @(negedge clk);
        ifc4.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ifc4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int seg_a, seg_b, seg_c, seg_d;
    int exp3 [7] = '{0, 1, 2, 0, 1, 2, 0};

    initial begin
        // Back-to-back beats with every consumer ready: strict rotation.
        add(1, 32'hA0, 4'b1111, 1, 1, 2'd0, 4'b0001, 0, 32'hA0);
        add(1, 32'hA1, 4'b1111, 1, 1, 2'd1, 4'b0010, 1, 32'hA1);
        add(1, 32'hA2, 4'b1111, 1, 1, 2'd2, 4'b0100, 2, 32'hA2);
        add(1, 32'hA3, 4'b1111, 1, 1, 2'd3, 4'b1000, 3, 32'hA3);
        add(1, 32'hA4, 4'b1111, 1, 1, 2'd0, 4'b0001, 0, 32'hA4);
        add(1, 32'hA5, 4'b1111, 1, 1, 2'd1, 4'b0010, 1, 32'hA5);
        add(0, 32'h00, 4'b1111, 1, 1, 2'd2, 4'b0000, 1, 32'hA5);
        seg_a = vec_q.size();
        // Consumers stalled: fill all four, then back-pressure, then a lone
        // out_ready[2] lets the held beat in; then channel 1 stays blocked.
        add(1, 32'hC0, 4'b0000, 1, 1, 2'd0, 4'b0001, 0, 32'hC0);
        add(1, 32'hC1, 4'b0000, 1, 1, 2'd1, 4'b0011, 1, 32'hC1);
        add(1, 32'hC2, 4'b0000, 1, 1, 2'd2, 4'b0111, 2, 32'hC2);
        add(1, 32'hC3, 4'b0000, 1, 1, 2'd3, 4'b1111, 3, 32'hC3);
        add(1, 32'hC4, 4'b0000, 0, 0, 2'd0, 4'b1111, 0, 32'hC0);
        add(1, 32'hC4, 4'b0100, 1, 1, 2'd2, 4'b1111, 2, 32'hC4);
        add(1, 32'hD0, 4'b1101, 1, 1, 2'd3, 4'b1010, 3, 32'hD0);
        add(1, 32'hD1, 4'b1101, 1, 1, 2'd0, 4'b0011, 0, 32'hD1);
        add(1, 32'hD2, 4'b1101, 1, 1, 2'd2, 4'b0110, 2, 32'hD2);
        add(1, 32'hD3, 4'b1101, 1, 1, 2'd3, 4'b1010, 3, 32'hD3);
        add(1, 32'hD4, 4'b1101, 1, 1, 2'd0, 4'b0011, 0, 32'hD4);
        add(0, 32'h00, 4'b1101, 1, 1, 2'd2, 4'b0010, 1, 32'hC1);
        seg_b = vec_q.size();
        // Fill, then drain-and-reload slot 0 in one edge, then drain 0 and 2.
        add(1, 32'h11, 4'b0000, 1, 1, 2'd0, 4'b0001, 0, 32'h11);
        add(1, 32'h12, 4'b0000, 1, 1, 2'd1, 4'b0011, 1, 32'h12);
        add(1, 32'h13, 4'b0000, 1, 1, 2'd2, 4'b0111, 2, 32'h13);
        add(1, 32'h14, 4'b0000, 1, 1, 2'd3, 4'b1111, 3, 32'h14);
        add(1, 32'h22, 4'b0001, 1, 1, 2'd0, 4'b1111, 0, 32'h22);
        add(0, 32'h00, 4'b0101, 1, 1, 2'd2, 4'b1010, 1, 32'h12);
        seg_c = vec_q.size();
        add(1, 32'hE0, 4'b1111, 1, 1, 2'd0, 4'b0001, 0, 32'hE0);
        seg_d = vec_q.size();

        rst_n = 1'b0;
        ifc4.in_valid = 1'b0; ifc4.in_data = '0; ifc4.out_ready = '0;
        ifc3.in_valid = 1'b0; ifc3.in_data = '0; ifc3.out_ready = '0;
        #3;
        check_output("reset out_valid", 64'(ifc4.out_valid), 64'h0);
        check_output("reset in_ready", 64'(ifc4.in_ready), 64'h1);
        check_output("reset in_channel", 64'(ifc4.in_channel), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vectors(0, seg_a);
        do_reset();
        run_vectors(seg_a, seg_b);
        do_reset();
        run_vectors(seg_b, seg_c);

        // Asynchronous reset between edges while slots 1 and 3 hold data.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async out_valid", 64'(ifc4.out_valid), 64'h0);
        check_output("async out_data", ifc4.out_data[63:0], 64'h0);
        check_output("async in_channel", 64'(ifc4.in_channel), 64'h0);
        check_output("async in_ready", 64'(ifc4.in_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vectors(seg_c, seg_d);

        // Non-power-of-two wrap on the WIDTH=3 instance.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ifc3.in_valid  = 1'b1;
            ifc3.in_data   = 32'h70 + 32'(i);
            ifc3.out_ready = 3'b111;
            #1;
            check_output($sformatf("w3 beat%0d in_channel", i), 64'(ifc3.in_channel), 64'(exp3[i]));
            @(posedge clk);
            #1;
            check_output($sformatf("w3 beat%0d out_valid", i), 64'(ifc3.out_valid), 64'(3'b001 << exp3[i]));
            check_output($sformatf("w3 beat%0d out_data", i),
                         64'(ifc3.out_data[exp3[i]*32 +: 32]), 64'(32'h70 + 32'(i)));
        end
        @(negedge clk);
        ifc3.in_valid = 1'b0;
        #1;
        check_output("w3 pointer after wrap", 64'(ifc3.in_channel), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
